kcpsm6_pwm_bank: RTL

- Multi-channel PWM output peripheral on the KCPSM6 (PicoBlaze) port bus.
- Successor to the single software-toggled LED output register: firmware writes duty values, and hardware generates NUM_CH LED/PWM waveforms with no per-edge processor intervention.
- Sits beside the kcpsm6 instance in a *_top wrapper and connects directly to port_id, out_port, write_strobe, read_strobe, in_port, interrupt and interrupt_ack.

---
 rtl/kcpsm6_pwm_pkg.sv | 29 ++
 rtl/pwm_channel.sv | 52 +++++
 rtl/kcpsm6_pwm_bank.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/kcpsm6_pwm_pkg.sv
// kcpsm6_pwm_pkg
//   Shared constants for the KCPSM6 PWM bank: period counter width and
//   register offsets relative to BASE_ADDR. Offsets after the duty block
//   depend on the channel count, so they are exposed as functions of NUM_CH.
package kcpsm6_pwm_pkg;

  localparam int CNT_W = 8;

  function automatic logic [7:0] ofs_enable(input int num_ch);
    return 8'(num_ch);
  endfunction

  function automatic logic [7:0] ofs_presc_lo(input int num_ch);
    return 8'(num_ch + 1);
  endfunction

  function automatic logic [7:0] ofs_presc_hi(input int num_ch);
    return 8'(num_ch + 2);
  endfunction

  function automatic logic [7:0] ofs_status(input int num_ch);
    return 8'(num_ch + 3);
  endfunction

  function automatic logic [7:0] ofs_count(input int num_ch);
    return 8'(num_ch + 4);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel
//   One PWM channel: shadow duty register written from the port bus, active
//   duty that reloads only on the period boundary while enabled, and a
//   registered compare output.
// Ports:
//   clk, reset      system clock, synchronous active-low reset
//   i_wr            write strobe for this channel's DUTY register
//   i_wr_data       duty value to store in the shadow
//   i_boundary      period-boundary tick (counter wrapping 255 -> 0)
//   i_enable        channel enable bit
//   i_cnt           shared period counter
//   o_duty          shadow duty, for readback
//   o_pwm           registered PWM output
module pwm_channel
  import kcpsm6_pwm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [7:0]       i_wr_data,
  input  logic             i_boundary,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [7:0]       o_duty,
  output logic             o_pwm
);

  logic [7:0] r_shadow;
  logic [7:0] r_active;
  logic       r_pwm;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wr)
        r_shadow <= i_wr_data;
      // A running channel only picks up a new duty at the wrap so a period
      // is never cut short or stretched; an idle channel tracks the shadow
      // so it starts with the latest value the moment it is enabled.
      if (i_boundary || !i_enable)
        r_active <= r_shadow;
      r_pwm <= i_enable & (i_cnt < r_active);
    end
  end

  assign o_duty = r_shadow;
  assign o_pwm  = r_pwm;

endmodule

// File: rtl/kcpsm6_pwm_bank.sv
// kcpsm6_pwm_bank
//   Multi-channel PWM peripheral on the KCPSM6 port bus. Holds the address
//   decode, the prescaler, the shared 8-bit period counter, the period
//   flag / interrupt and the registered read mux.
// Ports:
//   clk, reset      system clock, synchronous active-low reset
//   port_id         KCPSM6 port address
//   out_port        KCPSM6 write data
//   write_strobe    qualifies writes
//   read_strobe     qualifies reads (only used to clear STATUS)
//   in_port         registered read data
//   interrupt       period-complete interrupt request
//   interrupt_ack   KCPSM6 interrupt acknowledge
//   pwm_out         registered PWM outputs, bit i = channel i
module kcpsm6_pwm_bank
  import kcpsm6_pwm_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         PRESC_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        port_id,
  input  logic [7:0]        out_port,
  input  logic              write_strobe,
  input  logic              read_strobe,
  output logic [7:0]        in_port,
  output logic              interrupt,
  input  logic              interrupt_ack,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [7:0] OFS_ENABLE   = ofs_enable(NUM_CH);
  localparam logic [7:0] OFS_PRESC_LO = ofs_presc_lo(NUM_CH);
  localparam logic [7:0] OFS_PRESC_HI = ofs_presc_hi(NUM_CH);
  localparam logic [7:0] OFS_STATUS   = ofs_status(NUM_CH);
  localparam logic [7:0] OFS_COUNT    = ofs_count(NUM_CH);

  logic [NUM_CH-1:0]  r_enable;
  logic [7:0]         r_presc_lo;
  logic [PRESC_W-1:0] r_presc_reg;
  logic [PRESC_W-1:0] r_presc_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_flag;
  logic [7:0]         r_in_port;

  logic              w_in_win;
  logic [7:0]        w_ofs;
  logic              w_wr_enable;
  logic              w_wr_lo;
  logic              w_wr_hi;
  logic              w_rd_status;
  logic [15:0]       w_presc_full;
  logic              w_tick;
  logic              w_boundary;
  logic [7:0]        w_rd_data;
  logic [7:0]        w_duty_rd [NUM_CH];
  logic [NUM_CH-1:0] w_pwm;

  // Without the window check a port_id below BASE_ADDR would wrap into a
  // small offset and alias onto a register.
  assign w_in_win = (port_id >= BASE_ADDR);
  assign w_ofs    = port_id - BASE_ADDR;

  assign w_wr_enable = write_strobe & w_in_win & (w_ofs == OFS_ENABLE);
  assign w_wr_lo     = write_strobe & w_in_win & (w_ofs == OFS_PRESC_LO);
  assign w_wr_hi     = write_strobe & w_in_win & (w_ofs == OFS_PRESC_HI);
  assign w_rd_status = read_strobe  & w_in_win & (w_ofs == OFS_STATUS);

  assign w_presc_full = {out_port, r_presc_lo};
  assign w_tick       = (r_presc_cnt == r_presc_reg);
  assign w_boundary   = w_tick & (r_cnt == '1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_enable    <= '0;
      r_presc_lo  <= '0;
      r_presc_reg <= '0;
      r_presc_cnt <= '0;
      r_cnt       <= '0;
      r_flag      <= 1'b0;
      r_in_port   <= '0;
    end else begin
      if (w_wr_enable)
        r_enable <= out_port[NUM_CH-1:0];
      if (w_wr_lo)
        r_presc_lo <= out_port;

      // Committing a new prescale restarts the tick phase so the first
      // tick after the write is a full prescale interval away.
      if (w_wr_hi) begin
        r_presc_reg <= w_presc_full[PRESC_W-1:0];
        r_presc_cnt <= '0;
      end else if (w_tick) begin
        r_presc_cnt <= '0;
      end else begin
        r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
      end

      if (w_tick)
        r_cnt <= r_cnt + CNT_W'(1);

      // Set has priority so a boundary landing on an ack is never lost.
      if (w_boundary)
        r_flag <= 1'b1;
      else if (interrupt_ack || w_rd_status)
        r_flag <= 1'b0;

      r_in_port <= w_rd_data;
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    if (w_in_win) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_ofs == 8'(i))
          w_rd_data = w_duty_rd[i];
      end
      if (w_ofs == OFS_ENABLE)
        w_rd_data = 8'(r_enable);
      if (w_ofs == OFS_PRESC_LO)
        w_rd_data = 8'h00;
      if (w_ofs == OFS_STATUS)
        w_rd_data = {7'b0, r_flag};
      if (w_ofs == OFS_COUNT)
        w_rd_data = 8'(r_cnt);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel u_ch (
      .clk        (clk),
      .reset      (reset),
      .i_wr       (write_strobe & w_in_win & (w_ofs == 8'(g))),
      .i_wr_data  (out_port),
      .i_boundary (w_boundary),
      .i_enable   (r_enable[g]),
      .i_cnt      (r_cnt),
      .o_duty     (w_duty_rd[g]),
      .o_pwm      (w_pwm[g])
    );
  end

  assign in_port   = r_in_port;
  assign interrupt = r_flag & (|r_enable);
  assign pwm_out   = w_pwm;

endmodule
